// File: rtl/weight_buffer_writer_pkg.sv
// Shared constants and FSM encoding for the weight buffer writer and its reader.
// Shape bus layout is {w, h, c} with 16-bit fields.
package weight_buffer_writer_pkg;

    localparam int unsigned N_BUF_X     = 5;
    localparam int unsigned B_BUF_ADDR  = 9;
    localparam int unsigned B_SHAPE     = 48;
    localparam int unsigned DATA_WIDTH  = 64;
    localparam int unsigned CH_PER_WORD = 64;

    localparam int unsigned C_OFS = 0;
    localparam int unsigned H_OFS = 16;
    localparam int unsigned W_OFS = 32;

    localparam int unsigned B_DIM  = 16;
    localparam int unsigned B_WRAP = B_DIM - $clog2(CH_PER_WORD);
    localparam int unsigned B_BANK = $clog2(N_BUF_X);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStream,
        StDone
    } wbw_state_e;

    function automatic logic [N_BUF_X-1:0] bank_onehot(logic [B_BANK-1:0] bank);
        return N_BUF_X'(1) << bank;
    endfunction

endpackage

// File: rtl/weight_buffer_writer_if.sv
// AXI4-Stream style weight word stream from the DDR read DMA.
// master = DMA side, slave = writer side.
interface weight_buffer_writer_if;

    logic [weight_buffer_writer_pkg::DATA_WIDTH-1:0] tdata;
    logic                                            tvalid;
    logic                                            tlast;
    logic                                            tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/wbuf_addr_gen.sv
// Multiplier-free bank/address walker: k innermost, then y, then x; each column of
// h*n_wrap words fills one bank, banks rotate and the base steps by col_words per round.
module wbuf_addr_gen
    import weight_buffer_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [B_WRAP-1:0]     n_wrap,
    input  logic [B_DIM-1:0]      h,
    input  logic [B_DIM-1:0]      w,
    input  logic [B_BUF_ADDR-1:0] col_words,
    output logic [B_BANK-1:0]     bank,
    output logic [B_BUF_ADDR-1:0] addr,
    output logic                  last
);

    logic [B_WRAP-1:0]     k_q;
    logic [B_DIM-1:0]      y_q;
    logic [B_DIM-1:0]      x_q;
    logic [B_BANK-1:0]     rx_q;
    logic [B_BUF_ADDR-1:0] base_q;
    logic [B_BUF_ADDR-1:0] addr_q;

    logic                  k_last;
    logic                  y_last;
    logic                  x_last;
    logic                  rx_last;
    logic [B_BUF_ADDR-1:0] base_next;

    assign k_last    = (k_q == n_wrap - B_WRAP'(1));
    assign y_last    = (y_q == h - B_DIM'(1));
    assign x_last    = (x_q == w - B_DIM'(1));
    assign rx_last   = (rx_q == B_BANK'(N_BUF_X - 1));
    // Address space wraps modulo 2^B_BUF_ADDR; firmware keeps tensors inside it.
    assign base_next = base_q + col_words;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            k_q    <= '0;
            y_q    <= '0;
            x_q    <= '0;
            rx_q   <= '0;
            base_q <= '0;
            addr_q <= '0;
        end else if (advance) begin
            if (!k_last) begin
                k_q    <= k_q + B_WRAP'(1);
                addr_q <= addr_q + B_BUF_ADDR'(1);
            end else begin
                k_q <= '0;
                if (!y_last) begin
                    y_q    <= y_q + B_DIM'(1);
                    addr_q <= addr_q + B_BUF_ADDR'(1);
                end else begin
                    y_q <= '0;
                    x_q <= x_last ? '0 : x_q + B_DIM'(1);
                    if (rx_last) begin
                        rx_q   <= '0;
                        base_q <= base_next;
                        addr_q <= base_next;
                    end else begin
                        rx_q   <= rx_q + B_BANK'(1);
                        addr_q <= base_q;
                    end
                end
            end
        end
    end

    assign bank = rx_q;
    assign addr = addr_q;
    assign last = k_last && y_last && x_last;

endmodule

// File: rtl/weight_buffer_writer.sv
// Scatters a DDR weight stream into N_BUF_X x-interleaved weight banks; bank x mod N_BUF_X,
// address n_wrap*(y + h*floor(x/N_BUF_X)) + k. All outputs are registered.
module weight_buffer_writer
    import weight_buffer_writer_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [B_SHAPE-1:0]             wei_shape,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    weight_buffer_writer_if.slave          axis,
    output logic [N_BUF_X-1:0]             wren,
    output logic [B_BUF_ADDR*N_BUF_X-1:0]  wraddr,
    output logic [DATA_WIDTH-1:0]          wrdata
);

    wbw_state_e                      state_q;
    logic [B_DIM-1:0]                w_q;
    logic [B_DIM-1:0]                h_q;
    logic [B_WRAP-1:0]               n_wrap_q;
    // Only the low B_BUF_ADDR bits of h*n_wrap matter since addresses wrap.
    logic [B_BUF_ADDR-1:0]           col_words_q;
    logic                            done_q;
    logic                            err_q;
    logic                            tready_q;
    logic [N_BUF_X-1:0]              wren_q;
    logic [B_BUF_ADDR*N_BUF_X-1:0]   wraddr_q;
    logic [DATA_WIDTH-1:0]           wrdata_q;

    logic                            beat;
    logic                            empty_shape;
    logic [B_BANK-1:0]               bank;
    logic [B_BUF_ADDR-1:0]           addr;
    logic                            last;
    logic [B_BUF_ADDR*N_BUF_X-1:0]   wraddr_d;
    logic [$clog2(CH_PER_WORD)-1:0]  unused_c_lsb;

    assign unused_c_lsb = wei_shape[C_OFS +: $clog2(CH_PER_WORD)];

    assign beat        = axis.tvalid && tready_q;
    assign empty_shape = (w_q == '0) || (h_q == '0) || (n_wrap_q == '0);

    wbuf_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_q == StLoad),
        .advance   (beat),
        .n_wrap    (n_wrap_q),
        .h         (h_q),
        .w         (w_q),
        .col_words (col_words_q),
        .bank      (bank),
        .addr      (addr),
        .last      (last)
    );

    always_comb begin
        wraddr_d = '0;
        for (int i = 0; i < N_BUF_X; i++) begin
            if (bank == B_BANK'(i)) begin
                wraddr_d[i*B_BUF_ADDR +: B_BUF_ADDR] = addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            w_q         <= '0;
            h_q         <= '0;
            n_wrap_q    <= '0;
            col_words_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tready_q    <= 1'b0;
            wren_q      <= '0;
            wraddr_q    <= '0;
            wrdata_q    <= '0;
        end else begin
            wren_q   <= '0;
            wraddr_q <= '0;
            if (beat) begin
                wren_q   <= bank_onehot(bank);
                wraddr_q <= wraddr_d;
                wrdata_q <= axis.tdata;
                // tlast only feeds the error flag; beat count alone ends the tensor.
                if (axis.tlast != last) begin
                    err_q <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        w_q      <= wei_shape[W_OFS +: B_DIM];
                        h_q      <= wei_shape[H_OFS +: B_DIM];
                        n_wrap_q <= wei_shape[C_OFS + $clog2(CH_PER_WORD) +: B_WRAP];
                        err_q    <= 1'b0;
                        state_q  <= StLoad;
                    end
                end
                StLoad: begin
                    col_words_q <= B_BUF_ADDR'(32'(h_q) * 32'(n_wrap_q));
                    if (empty_shape) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        tready_q <= 1'b1;
                        state_q  <= StStream;
                    end
                end
                StStream: begin
                    if (beat && last) begin
                        tready_q <= 1'b0;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    // After a stream, DONE holds one extra cycle so done trails the last write.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign err         = err_q;
    assign axis.tready = tready_q;
    assign wren        = wren_q;
    assign wraddr      = wraddr_q;
    assign wrdata      = wrdata_q;

endmodule

// File: tb/tb_weight_buffer_writer.sv
// Directed bench for weight_buffer_writer: expected bank writes come from the closed-form
// mapping, are queued as beats are accepted and checked as writes emerge.
module tb_weight_buffer_writer;
    import weight_buffer_writer_pkg::*;

    typedef struct {
        logic [N_BUF_X-1:0]            wren;
        logic [B_BUF_ADDR*N_BUF_X-1:0] wraddr;
        logic [DATA_WIDTH-1:0]         wrdata;
    } exp_t;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    logic                           start = 1'b0;
    logic [B_SHAPE-1:0]             wei_shape = '0;
    logic                           busy;
    logic                           done;
    logic                           err;
    logic [N_BUF_X-1:0]             wren;
    logic [B_BUF_ADDR*N_BUF_X-1:0]  wraddr;
    logic [DATA_WIDTH-1:0]          wrdata;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    weight_buffer_writer_if axis_if ();

    weight_buffer_writer dut (
        .clk       (clk),
        .rst       (rst),
        .wei_shape (wei_shape),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .axis      (axis_if),
        .wren      (wren),
        .wraddr    (wraddr),
        .wrdata    (wrdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Writes are sampled mid-cycle, one cycle after the accepting edge.
    always @(negedge clk) begin
        if (wren !== '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(wren), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wren", 64'(wren), 64'(e.wren));
                check("wraddr", 64'(wraddr), 64'(e.wraddr));
                check("wrdata", wrdata, e.wrdata);
            end
        end
    end

    task automatic send(input exp_t e, input logic d_last);
        int n = 0;
        axis_if.tvalid = 1'b1;
        axis_if.tdata  = e.wrdata;
        axis_if.tlast  = d_last;
        while (axis_if.tready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tready_wait", 64'(n < 50), 64'(1));
        if (n < 50) begin
            exp_q.push_back(e);
            @(negedge clk);
        end
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_tensor(input int tag, input int c, input int h, input int w,
                              input int gap_max, input int bad_idx, input bit drop_final,
                              input int start_at, input int abort_at);
        int   nwrap = (c >> 6) & 1023;
        int   nw = nwrap * h * w;
        int   idx = 0;
        bit   exp_err = (bad_idx >= 0) || drop_final;
        exp_t e;
        logic tl;
        logic [B_BUF_ADDR*N_BUF_X-1:0] a;

        start     = 1'b1;
        wei_shape = {16'(w), 16'(h), 16'(c)};
        @(negedge clk);
        start = 1'b0;
        check("load_busy", 64'(busy), 64'(1));
        check("load_done", 64'(done), 64'(0));
        check("start_clears_err", 64'(err), 64'(0));
        check("load_tready", 64'(axis_if.tready), 64'(0));

        if (nw == 0) begin
            @(negedge clk);
            check("empty_done", 64'(done), 64'(1));
            check("empty_tready", 64'(axis_if.tready), 64'(0));
            @(negedge clk);
            check("empty_idle_done", 64'(done), 64'(0));
            check("empty_idle_busy", 64'(busy), 64'(0));
            return;
        end

        for (int x = 0; x < w; x++) begin
            for (int y = 0; y < h; y++) begin
                for (int k = 0; k < nwrap; k++) begin
                    if (idx == abort_at) begin
                        rst = 1'b1;
                        @(negedge clk);
                        check("abort_tready", 64'(axis_if.tready), 64'(0));
                        check("abort_wren", 64'(wren), 64'(0));
                        check("abort_busy", 64'(busy), 64'(0));
                        check("abort_queue", 64'(exp_q.size()), 64'(0));
                        rst = 1'b0;
                        return;
                    end
                    repeat ($urandom_range(0, gap_max)) begin
                        @(negedge clk);
                        check("gap_wren", 64'(wren), 64'(0));
                    end
                    a        = (B_BUF_ADDR*N_BUF_X)'(9'(nwrap * (y + h * (x / 5)) + k));
                    e.wren   = 5'(1) << (x % 5);
                    e.wraddr = a << ((x % 5) * 9);
                    e.wrdata = {8'(tag), 56'(idx)};
                    tl = (idx == nw - 1) ? !drop_final : (idx == bad_idx);
                    if (idx == start_at) begin
                        start     = 1'b1;
                        wei_shape = 48'h0001_0001_0040;
                    end
                    send(e, tl);
                    idx++;
                end
            end
        end

        check("final_done_early", 64'(done), 64'(0));
        check("final_busy", 64'(busy), 64'(1));
        check("tready_drop", 64'(axis_if.tready), 64'(0));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(1));
        check("done_busy", 64'(busy), 64'(1));
        @(negedge clk);
        check("done_clear", 64'(done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("err_flag", 64'(err), 64'(exp_err));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;
        axis_if.tdata  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_tready", 64'(axis_if.tready), 64'(0));
        check("rst_wren", 64'(wren), 64'(0));
        check("rst_wraddr", 64'(wraddr), 64'(0));
        check("rst_wrdata", wrdata, 64'(0));
        rst = 1'b0;
        @(negedge clk);

        run_tensor(1, 64, 3, 7, 0, -1, 1'b0, -1, -1);
        run_tensor(2, 128, 2, 2, 0, -1, 1'b0, -1, -1);
        run_tensor(3, 128, 2, 2, 3, -1, 1'b0, -1, -1);
        run_tensor(4, 64, 3, 7, 0, 9, 1'b1, -1, -1);
        run_tensor(5, 32, 3, 7, 0, -1, 1'b0, -1, -1);
        run_tensor(6, 64, 0, 4, 0, -1, 1'b0, -1, -1);
        run_tensor(7, 64, 3, 7, 0, -1, 1'b0, -1, 10);
        run_tensor(1, 64, 3, 7, 0, -1, 1'b0, -1, -1);
        run_tensor(8, 64, 3, 7, 1, -1, 1'b0, 7, -1);
        run_tensor(9, 192, 2, 6, 0, -1, 1'b0, -1, -1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
